instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address assigned to the first emitted instruction.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 IN_VALID  input  1  request carries a valid instruction description.
REQ-005 IN_READY  output  1  encoder can accept a request this cycle.
REQ-006 IN_KIND  input  4  0 R-type, 1 addi, 2 andi, 3 ori, 4 slti, 5 sw, 6 lw, 7 j, 8 beq, 9 bne; 10-15 illegal.
REQ-007 IN_RS, IN_RT, IN_RD  input  5 each  register fields.
REQ-008 IN_FUNCT  input  6  R-type function field.
REQ-009 IN_IMM  input  16  immediate or branch offset, passed unmodified.
REQ-010 IN_TARGET  input  26  jump target field.
REQ-011 OUT_VALID  output  1  OUT_INSTR/OUT_ADDR hold a valid encoded word.
REQ-012 OUT_READY  input  1  downstream, e.g. an instruction-memory writer, takes the word.
REQ-013 OUT_INSTR  output  32  encoded MIPS instruction at the buffer head.
REQ-014 OUT_ADDR  output  32  byte address of OUT_INSTR.
REQ-015 ERR  output  1  sticky flag: an illegal IN_KIND was accepted.
REQ-016 COUNT  output  16  number of words popped, saturating.

Function
REQ-017 Input handshake SHALL complete when IN_VALID & IN_READY are both high at a rising edge; output handshake when OUT_VALID & OUT_READY are both high.
REQ-018 Encoding SHALL be: R-type {6'b000000, RS, RT, RD, 5'b00000, FUNCT}; I-type {op, RS, RT, IMM}; j {6'b000010, TARGET}.
REQ-019 I-type opcodes SHALL be: addi 001000, andi 001100, ori 001101, slti 001010, sw 101011, lw 100011, beq 000100, bne 000101.
REQ-020 Encoded words SHALL be held in a 2-entry FIFO; IN_READY = not full, independent of OUT_READY, with no same-cycle bypass.
REQ-021 Latency SHALL be 1 cycle: a word accepted at edge N into an empty FIFO drives OUT_VALID high after edge N.
REQ-022 OUT_VALID SHALL equal FIFO non-empty; OUT_INSTR and OUT_ADDR SHALL stay stable while OUT_VALID=1 and OUT_READY=0.
REQ-023 A simultaneous push and pop with 1 entry SHALL leave occupancy at 1, with the new word at the head after the pop.
REQ-024 A simultaneous push and pop is impossible when full; a pop when full SHALL free one slot so IN_READY=1 in the next cycle.
REQ-025 Words SHALL leave the FIFO in acceptance order.
REQ-026 An address counter SHALL start at BASE_ADDR and add 4 on every pop, wrapping from 32'hFFFF_FFFC to 0; OUT_ADDR = counter value.
REQ-027 An accepted illegal IN_KIND SHALL be consumed and dropped: no FIFO push, no address change, ERR set to 1 from the next cycle.
REQ-028 ERR SHALL clear only on reset.
REQ-029 COUNT SHALL increment on every pop and hold at 16'hFFFF.

Reset
REQ-030 While RST=1: FIFO empty, OUT_VALID=0, IN_READY=0, address counter=BASE_ADDR, ERR=0, COUNT=0.
REQ-031 OUT_INSTR value during reset is don't-care.
REQ-032 Reset asserted mid-stream SHALL discard buffered words immediately, without waiting for a clock edge.
REQ-033 IN_READY SHALL be 1 in the first cycle after RST deasserts.

Verification
REQ-034 addi RS=1 RT=2 IMM=0x0005, OUT_READY=1 -> next cycle OUT_VALID=1, OUT_INSTR=0x20220005, OUT_ADDR=BASE_ADDR; COUNT=1 after the pop.
REQ-035 Sequence R-type(1,2,3,FUNCT=0x20), lw(RS=29,RT=8,IMM=4), j(TARGET=0x10), beq(1,2,IMM=0xFFFF), OUT_READY=1 -> words 0x00221820, 0x8FA80004, 0x08000010, 0x1022FFFF at addresses BASE, +4, +8, +12.
REQ-036 OUT_READY=0 with 3 valid requests -> 2 accepted, IN_READY=0, head word stable; OUT_READY=1 for one cycle -> 3rd accepted, order preserved.
REQ-037 IN_KIND=12, then ori RS=0 RT=5 IMM=0x00FF -> ERR=1; only 0x340500FF emitted, at BASE_ADDR.
REQ-038 BASE_ADDR=32'hFFFF_FFFC, two words popped -> OUT_ADDR 0xFFFFFFFC then 0x00000000.
REQ-039 RST pulsed while 2 words are buffered -> OUT_VALID=0 immediately; after release ERR=0, COUNT=0, address=BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: encodes MIPS instruction descriptions into a 2-entry FIFO of words tagged with sequential byte addresses.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [3:0]  in_kind_i,
  input  logic [4:0]  in_rs_i,
  input  logic [4:0]  in_rt_i,
  input  logic [4:0]  in_rd_i,
  input  logic [5:0]  in_funct_i,
  input  logic [15:0] in_imm_i,
  input  logic [25:0] in_target_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_addr_o,
  output logic        err_o,
  output logic [15:0] count_o
);
  logic [31:0] slot0_q, slot0_d, slot1_q, slot1_d, addr_q, word;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] count_q;
  logic [5:0]  op;
  logic        err_q, legal, acc, push, pop;
  always_comb begin
    op    = 6'b000000;
    legal = 1'b1;
    case (in_kind_i)
      4'd0:    op = 6'b000000;
      4'd1:    op = 6'b001000;
      4'd2:    op = 6'b001100;
      4'd3:    op = 6'b001101;
      4'd4:    op = 6'b001010;
      4'd5:    op = 6'b101011;
      4'd6:    op = 6'b100011;
      4'd7:    op = 6'b000010;
      4'd8:    op = 6'b000100;
      4'd9:    op = 6'b000101;
      default: legal = 1'b0;
    endcase
    word = in_kind_i == 4'd0 ? {op, in_rs_i, in_rt_i, in_rd_i, 5'b00000, in_funct_i} :
           in_kind_i == 4'd7 ? {op, in_target_i} : {op, in_rs_i, in_rt_i, in_imm_i};
  end
  // reset gates ready combinationally so it is low for the whole reset pulse
  assign in_ready_o  = ~rst_i & (cnt_q != 2'd2);
  assign out_valid_o = cnt_q != 2'd0;
  assign out_instr_o = slot0_q;
  assign out_addr_o  = addr_q;
  assign err_o       = err_q;
  assign count_o     = count_q;
  assign acc  = in_valid_i & in_ready_o;
  assign push = acc & legal;
  assign pop  = out_valid_o & out_ready_i;
  // slot0 is the head; stale contents of an empty slot are never observed
  always_comb begin
    cnt_d   = cnt_q + {1'b0, push} - {1'b0, pop};
    slot0_d = pop ? (cnt_q == 2'd2 ? slot1_q : word) : (cnt_q == 2'd0 ? word : slot0_q);
    slot1_d = (push & ~pop & cnt_q == 2'd1) ? word : slot1_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= 2'd0;
      slot0_q <= 32'd0;
      slot1_q <= 32'd0;
      addr_q  <= BASE_ADDR;
      err_q   <= 1'b0;
      count_q <= 16'd0;
    end else begin
      cnt_q   <= cnt_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      if (pop) addr_q <= addr_q + 32'd4;
      if (acc & ~legal) err_q <= 1'b1;
      if (pop & (count_q != 16'hFFFF)) count_q <= count_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized and directed checks of instr_encoder against a queue-based reference model.
module tb_instr_encoder;
  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam logic [31:0] WBASE = 32'hFFFF_FFFC;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] in_kind = '0;
  logic [4:0] in_rs = '0, in_rt = '0, in_rd = '0;
  logic [5:0] in_funct = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic in_ready, out_valid, err, w_in_ready, w_valid, w_err;
  logic [31:0] out_instr, out_addr, w_instr, w_addr;
  logic [15:0] count, w_count;
  int vecs = 0, errs = 0;
  logic [31:0] m_q[$];
  logic [31:0] m_addr, m_addr2;
  logic m_err;
  logic [15:0] m_count;

  instr_encoder #(.BASE_ADDR(BASE)) u_dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .in_kind_i(in_kind),
    .in_rs_i(in_rs), .in_rt_i(in_rt), .in_rd_i(in_rd), .in_funct_i(in_funct), .in_imm_i(in_imm),
    .in_target_i(in_target), .out_valid_o(out_valid), .out_ready_i(out_ready), .out_instr_o(out_instr),
    .out_addr_o(out_addr), .err_o(err), .count_o(count));
  instr_encoder #(.BASE_ADDR(WBASE)) u_wrap (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(w_in_ready), .in_kind_i(in_kind),
    .in_rs_i(in_rs), .in_rt_i(in_rt), .in_rd_i(in_rd), .in_funct_i(in_funct), .in_imm_i(in_imm),
    .in_target_i(in_target), .out_valid_o(w_valid), .out_ready_i(out_ready), .out_instr_o(w_instr),
    .out_addr_o(w_addr), .err_o(w_err), .count_o(w_count));

  always #5 clk = ~clk;

  // returns {legal, word}
  function automatic logic [32:0] ref_enc(input logic [3:0] k, input logic [4:0] rs, rt, rd,
                                          input logic [5:0] f, input logic [15:0] imm, input logic [25:0] tg);
    logic [5:0] op;
    if (k > 4'd9) return 33'd0;
    if (k == 4'd0) return {1'b1, 6'd0, rs, rt, rd, 5'd0, f};
    if (k == 4'd7) return {1'b1, 6'h02, tg};
    case (k)
      4'd1: op = 6'h08;
      4'd2: op = 6'h0C;
      4'd3: op = 6'h0D;
      4'd4: op = 6'h0A;
      4'd5: op = 6'h2B;
      4'd6: op = 6'h23;
      4'd8: op = 6'h04;
      default: op = 6'h05;
    endcase
    return {1'b1, op, rs, rt, imm};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_addr = BASE;
    m_addr2 = WBASE;
    m_err = 1'b0;
    m_count = 16'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic apply(input logic v, input logic [3:0] k, input logic [4:0] rs, rt, rd,
                       input logic [5:0] f, input logic [15:0] imm, input logic [25:0] tg, input logic ordy);
    logic [32:0] e;
    logic pop, acc;
    in_valid = v; in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd;
    in_funct = f; in_imm = imm; in_target = tg; out_ready = ordy;
    e = ref_enc(k, rs, rt, rd, f, imm, tg);
    pop = ordy && m_q.size() != 0;
    acc = v && m_q.size() < 2;
    @(posedge clk);
    #1;
    if (pop) begin
      void'(m_q.pop_front());
      m_addr += 32'd4;
      m_addr2 += 32'd4;
      if (m_count != 16'hFFFF) m_count++;
    end
    if (acc) begin
      if (e[32]) m_q.push_back(e[31:0]);
      else m_err = 1'b1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %0b want 0", out_valid); end
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rst_ready got %0b want 0", in_ready); end
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL rst_err got %0b want 0", err); end
    vecs++; if (count !== 16'd0) begin errs++; $display("FAIL rst_count got %h want 0", count); end
    vecs++; if (out_addr !== BASE) begin errs++; $display("FAIL rst_addr got %h want %h", out_addr, BASE); end
    rst = 1'b0;
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rel_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_addi();
    apply(1'b1, 4'd1, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0005, 26'd0, 1'b1);
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL addi_valid got %0b want 1", out_valid); end
    vecs++; if (out_instr !== 32'h20220005) begin errs++; $display("FAIL addi_instr got %h want 20220005", out_instr); end
    vecs++; if (out_addr !== BASE) begin errs++; $display("FAIL addi_addr got %h want %h", out_addr, BASE); end
    apply(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b1);
    vecs++; if (count !== 16'd1) begin errs++; $display("FAIL addi_count got %h want 1", count); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL addi_empty got %0b want 0", out_valid); end
  endtask

  task automatic test_sequence();
    logic [31:0] words [4] = '{32'h00221820, 32'h8FA80004, 32'h08000010, 32'h1022FFFF};
    logic [31:0] start;
    start = BASE + 32'd4;
    apply(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0, 1'b1);
    vecs++; if (out_instr !== words[0] || out_addr !== start) begin errs++; $display("FAIL seq0 got %h@%h want %h@%h", out_instr, out_addr, words[0], start); end
    apply(1'b1, 4'd6, 5'd29, 5'd8, 5'd0, 6'd0, 16'd4, 26'd0, 1'b1);
    vecs++; if (out_instr !== words[1] || out_addr !== start + 32'd4) begin errs++; $display("FAIL seq1 got %h@%h want %h@%h", out_instr, out_addr, words[1], start + 32'd4); end
    apply(1'b1, 4'd7, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 1'b1);
    vecs++; if (out_instr !== words[2] || out_addr !== start + 32'd8) begin errs++; $display("FAIL seq2 got %h@%h want %h@%h", out_instr, out_addr, words[2], start + 32'd8); end
    apply(1'b1, 4'd8, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b1);
    vecs++; if (out_instr !== words[3] || out_addr !== start + 32'd12) begin errs++; $display("FAIL seq3 got %h@%h want %h@%h", out_instr, out_addr, words[3], start + 32'd12); end
    apply(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b1);
    vecs++; if (count !== 16'd5) begin errs++; $display("FAIL seq_count got %h want 5", count); end
  endtask

  task automatic test_backpressure();
    logic [15:0] imm [3];
    logic [31:0] w [3];
    for (int i = 0; i < 3; i++) begin
      imm[i] = 16'($urandom);
      w[i] = {6'h0D, 5'd3, 5'(i + 4), imm[i]};
    end
    for (int i = 0; i < 3; i++) apply(1'b1, 4'd3, 5'd3, 5'(i + 4), 5'd0, 6'd0, imm[i], 26'd0, 1'b0);
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_ready got %0b want 0", in_ready); end
    vecs++; if (out_instr !== w[0]) begin errs++; $display("FAIL bp_head got %h want %h", out_instr, w[0]); end
    apply(1'b1, 4'd3, 5'd3, 5'd6, 5'd0, 6'd0, imm[2], 26'd0, 1'b1);
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_free got %0b want 1", in_ready); end
    vecs++; if (out_instr !== w[1]) begin errs++; $display("FAIL bp_next got %h want %h", out_instr, w[1]); end
    apply(1'b1, 4'd3, 5'd3, 5'd6, 5'd0, 6'd0, imm[2], 26'd0, 1'b0);
    apply(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b1);
    vecs++; if (out_instr !== w[2] || out_valid !== 1'b1) begin errs++; $display("FAIL bp_third got %h/%0b want %h/1", out_instr, out_valid, w[2]); end
    apply(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b1);
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL bp_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_illegal();
    do_reset();
    apply(1'b1, 4'd12, 5'd7, 5'd7, 5'd7, 6'd7, 16'h1234, 26'd0, 1'b1);
    vecs++; if (err !== 1'b1) begin errs++; $display("FAIL ill_err got %0b want 1", err); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL ill_push got %0b want 0", out_valid); end
    apply(1'b1, 4'd3, 5'd0, 5'd5, 5'd0, 6'd0, 16'h00FF, 26'd0, 1'b1);
    vecs++; if (out_instr !== 32'h340500FF || out_addr !== BASE) begin errs++; $display("FAIL ill_ori got %h@%h want 340500ff@%h", out_instr, out_addr, BASE); end
    apply(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b1);
    vecs++; if (out_valid !== 1'b0 || err !== 1'b1 || count !== 16'd1) begin errs++; $display("FAIL ill_after got v%0b e%0b c%h want v0 e1 c1", out_valid, err, count); end
  endtask

  task automatic test_wrap();
    do_reset();
    apply(1'b1, 4'd1, 5'd1, 5'd1, 5'd0, 6'd0, 16'd1, 26'd0, 1'b0);
    vecs++; if (w_addr !== 32'hFFFFFFFC) begin errs++; $display("FAIL wrap0 got %h want fffffffc", w_addr); end
    apply(1'b1, 4'd1, 5'd1, 5'd1, 5'd0, 6'd0, 16'd2, 26'd0, 1'b1);
    vecs++; if (w_addr !== 32'h0 || w_valid !== 1'b1) begin errs++; $display("FAIL wrap1 got %h/%0b want 00000000/1", w_addr, w_valid); end
    apply(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b1);
    vecs++; if (w_addr !== 32'h4) begin errs++; $display("FAIL wrap2 got %h want 00000004", w_addr); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 11)), 5'($urandom), 5'($urandom), 5'($urandom),
            6'($urandom), 16'($urandom), 26'($urandom), 1'($urandom));
      vecs++; if (out_valid !== (m_q.size() != 0)) begin errs++; $display("FAIL rnd_valid @%0d got %0b want %0b", i, out_valid, m_q.size() != 0); end
      vecs++; if (in_ready !== (m_q.size() < 2)) begin errs++; $display("FAIL rnd_ready @%0d got %0b want %0b", i, in_ready, m_q.size() < 2); end
      if (m_q.size() != 0) begin
        vecs++; if (out_instr !== m_q[0]) begin errs++; $display("FAIL rnd_instr @%0d got %h want %h", i, out_instr, m_q[0]); end
      end
      vecs++; if (out_addr !== m_addr || w_addr !== m_addr2) begin errs++; $display("FAIL rnd_addr @%0d got %h/%h want %h/%h", i, out_addr, w_addr, m_addr, m_addr2); end
      vecs++; if (err !== m_err || count !== m_count) begin errs++; $display("FAIL rnd_stat @%0d got e%0b c%h want e%0b c%h", i, err, count, m_err, m_count); end
    end
  endtask

  task automatic test_midstream();
    apply(1'b1, 4'd15, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b1);
    apply(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b1);
    apply(1'b1, 4'd2, 5'd1, 5'd2, 5'd0, 6'd0, 16'hAAAA, 26'd0, 1'b0);
    apply(1'b1, 4'd4, 5'd3, 5'd4, 5'd0, 6'd0, 16'h5555, 26'd0, 1'b0);
    vecs++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errs++; $display("FAIL mid_full got v%0b r%0b want v1 r0", out_valid, in_ready); end
    #1 rst = 1'b1;
    #1;
    vecs++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errs++; $display("FAIL mid_async got v%0b r%0b want v0 r0", out_valid, in_ready); end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    vecs++; if (err !== 1'b0 || count !== 16'd0 || out_addr !== BASE || in_ready !== 1'b1) begin errs++; $display("FAIL mid_release got e%0b c%h a%h r%0b want e0 c0 a%h r1", err, count, out_addr, in_ready, BASE); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_sequence();
    test_backpressure();
    test_illegal();
    test_wrap();
    test_random();
    test_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
